vga_timing: RTL

Raster timing generator for the VGA output path. It sits between the PLL pixel clock and the `video` pixel/colour stage, and tells that stage where the beam is. It produces registered horizontal and vertical sync, an active-video flag, pixel coordinates, and line/frame start strobes. The horizontal and vertical timing is parameterised; the defaults give 640x480@60 Hz with a 25.175 MHz pixel clock.

---
 rtl/vga_timing.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator (hsync/vsync/active/x/y/strobes).
// Ports: clk, reset (async high), en (pixel advance) -> Hsync, Vsync,
//   active, x[9:0], y[9:0], line_start, frame_start, and frame_cnt[15:0]
//   only when VGA_TIMING_FRAMECNT_EN is defined.
module vga_timing #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic        Hsync,
   output logic        Vsync,
   output logic        active,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
  ,output logic [15:0] frame_cnt
`endif
);

   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic [9:0] x_q, y_q;
   logic       hs_q, vs_q, act_q, ls_q, fs_q;
   logic       hs_d, vs_d, act_d;
   logic       at_org;

   assign at_org = (hc_q == 10'd0) && (vc_q == 10'd0);

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (en) begin
         if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
   end

   // Decode uses the current counters; outputs land one enabled clock later
   always_comb begin
      act_d = (hc_q < H_ACT) && (vc_q < V_ACT);
      hs_d  = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? H_POL : ~H_POL;
      vs_d  = ((vc_q >= VS_BEG) && (vc_q < VS_END)) ? V_POL : ~V_POL;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hc_q  <= 10'd0;
         vc_q  <= 10'd0;
         x_q   <= 10'd0;
         y_q   <= 10'd0;
         act_q <= 1'b0;
         hs_q  <= ~H_POL;
         vs_q  <= ~V_POL;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
         if (en) begin
            x_q   <= hc_q;
            y_q   <= vc_q;
            act_q <= act_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
         end
         // Strobes drop on idle clocks so each pulse is one clk wide
         ls_q <= en && (hc_q == 10'd0);
         fs_q <= en && at_org;
      end
   end

`ifdef VGA_TIMING_FRAMECNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_q <= 16'd0;
      end else if (en && at_org) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign x           = x_q;
   assign y           = y_q;
   assign active      = act_q;
   assign Hsync       = hs_q;
   assign Vsync       = vs_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule
